// File: rtl/uart_baud_gen.sv
// uart_baud_gen: UART baud tick generator with table/custom divisor, TX/RX phase,
// and optional frame autostop enabled by defining UART_BAUD_GEN_AUTOSTOP_EN.
module uart_baud_gen #(
    parameter int SYS_CLK    = 50_000_000,
    parameter int OVERSAMPLE = 1,
    parameter int MODE       = 0,
    parameter int DIV_W      = 16,
    parameter int FRAME_BITS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       baud_set,
    input  logic [DIV_W-1:0] div_custom,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic             tick,
    output logic             done
);

    function automatic logic [DIV_W-1:0] div_for(input int rate);
        return DIV_W'(SYS_CLK / (rate * OVERSAMPLE) - 1);
    endfunction

    localparam logic [7:0][DIV_W-1:0] DIV_TAB = {
        div_for(921_600), div_for(460_800), div_for(230_400), div_for(115_200),
        div_for(57_600),  div_for(38_400),  div_for(19_200),  div_for(9_600)
    };

    if (!(OVERSAMPLE == 1 || OVERSAMPLE == 8 || OVERSAMPLE == 16) || FRAME_BITS < 1 ||
        (64'(SYS_CLK / (9600 * OVERSAMPLE)) >> DIV_W) != 64'd0) begin : g_cfg_err
        $error("uart_baud_gen: illegal parameter combination");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, next_state;
    logic [DIV_W-1:0] div_q, div_sel, cnt, cnt_d, rx_phase;
    logic [DIV_W:0]   div_p1;
    logic             accept, wrap, run_next, tick_d;

    // State register; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // Next state: stop beats start in IDLE; stop or frame end leaves RUN.
    always_comb begin
        next_state = (state == IDLE) ? ((start && !stop) ? RUN : IDLE)
                                     : ((stop || done) ? IDLE : RUN);
    end

    // Outputs decoded from state.
    always_comb begin
        busy = (state == RUN);
    end

    // Divisor selection, RX half-period preload and period counter next value.
    always_comb begin
        div_sel  = baud_set[3] ? ((div_custom == '0) ? DIV_W'(1) : div_custom)
                               : DIV_TAB[baud_set[2:0]];
        div_p1   = {1'b0, div_sel} + (DIV_W+1)'(1);
        rx_phase = DIV_W'(div_p1 - (div_p1 >> 1));
        accept   = (state == IDLE) && (next_state == RUN);
        run_next = (next_state == RUN);
        wrap     = (cnt == div_q);
        tick_d   = run_next && (accept ? (MODE == 0) : wrap);
        cnt_d    = !run_next ? '0
                 : accept    ? ((MODE == 0) ? '0 : rx_phase)
                 : wrap      ? '0
                 : cnt + DIV_W'(1);
    end

    // Period counter, latched divisor and registered tick.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt   <= '0;
            div_q <= DIV_TAB[0];
            tick  <= 1'b0;
        end else begin
            cnt   <= cnt_d;
            div_q <= accept ? div_sel : div_q;
            tick  <= tick_d;
        end
    end

`ifdef UART_BAUD_GEN_AUTOSTOP_EN
    localparam int N_TICKS = FRAME_BITS * OVERSAMPLE;
    localparam int TW      = $clog2(N_TICKS + 1);

    logic [TW-1:0] tcnt, tcnt_inc;
    logic          done_d;

    // Ticks issued so far in this frame; done marks the last one.
    always_comb begin
        tcnt_inc = tcnt + TW'(1);
        done_d   = tick_d && (tcnt_inc == TW'(N_TICKS));
    end

    // Frame tick counter and done pulse registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tcnt <= '0;
            done <= 1'b0;
        end else begin
            tcnt <= !run_next ? '0 : tick_d ? tcnt_inc : tcnt;
            done <= done_d;
        end
    end
`else
    assign done = 1'b0;
`endif

endmodule

// File: tb/tb_uart_baud_gen.sv
// tb_uart_baud_gen: randomized checks of TX and RX instances against a tick-schedule model.
module tb_uart_baud_gen;

    localparam int SYS_CLK = 50_000_000;
    localparam int OS      = 1;
    localparam int DW      = 16;
    localparam int FB      = 10;
    localparam int NT      = FB * OS;
    localparam int BIG     = 1 << 30;
`ifdef UART_BAUD_GEN_AUTOSTOP_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic          clk = 1'b0, rst = 1'b0, start = 1'b0, stop = 1'b0;
    logic [3:0]    baud_set = 4'd0;
    logic [DW-1:0] div_custom = '0;
    logic          tick_tx, busy_tx, done_tx, tick_rx, busy_rx, done_rx;
    logic [1:0]    tick_v, busy_v, done_v;
    int            cyc = 0, vectors = 0, miscompares = 0;

    assign tick_v = {tick_rx, tick_tx};
    assign busy_v = {busy_rx, busy_tx};
    assign done_v = {done_rx, done_tx};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_baud_gen #(.SYS_CLK(SYS_CLK), .OVERSAMPLE(OS), .MODE(0), .DIV_W(DW), .FRAME_BITS(FB)) dut_tx (
        .clk(clk), .rst(rst), .baud_set(baud_set), .div_custom(div_custom),
        .start(start), .stop(stop), .busy(busy_tx), .tick(tick_tx), .done(done_tx));

    uart_baud_gen #(.SYS_CLK(SYS_CLK), .OVERSAMPLE(OS), .MODE(1), .DIV_W(DW), .FRAME_BITS(FB)) dut_rx (
        .clk(clk), .rst(rst), .baud_set(baud_set), .div_custom(div_custom),
        .start(start), .stop(stop), .busy(busy_rx), .tick(tick_rx), .done(done_rx));

    // One accepted run per instance: start cycle, divisor, and the cycle stop/reset hit it.
    typedef struct {bit on; int s; int d; int stop_at;} sched_t;
    sched_t sch[2];

    function automatic void model(input int i, input int t, output bit tk, output bit bs, output bit dn);
        int p, first, last;
        tk = 0; bs = 0; dn = 0;
        if (!sch[i].on || t <= sch[i].s || t > sch[i].stop_at) return;
        p     = sch[i].d + 1;
        first = sch[i].s + 1 + ((i == 1) ? p / 2 : 0);
        last  = AUTO ? first + (NT - 1) * p : BIG;
        if (t > last) return;
        bs = 1;
        tk = (t >= first) && ((t - first) % p == 0);
        dn = AUTO && (t == last);
    endfunction

    function automatic int exp_div(input logic [3:0] bs, input logic [DW-1:0] dc);
        int rates[8] = '{9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600};
        if (bs[3]) return (dc == 0) ? 1 : int'(dc);
        return SYS_CLK / (rates[bs[2:0]] * OS) - 1;
    endfunction

    // Applies this cycle's control inputs and updates the schedule model accordingly.
    task automatic drive(input bit st, input bit sp, input bit rn);
        bit tk, bs, dn;
        for (int i = 0; i < 2; i++) begin
            model(i, cyc, tk, bs, dn);
            if (!rn || sp) begin
                if (bs) sch[i].stop_at = cyc;
            end else if (st && !bs) begin
                sch[i] = '{1'b1, cyc, exp_div(baud_set, div_custom), BIG};
            end
        end
        start = st; stop = sp; rst = rn;
    endtask

    task automatic test_reset();
        bit et, eb, ed;
        sch[0].on = 0; sch[1].on = 0;
        repeat (2) @(posedge clk);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                model(i, cyc, et, eb, ed);
                vectors++;
                if ({tick_v[i], busy_v[i], done_v[i]} !== {et, eb, ed}) begin
                    miscompares++;
                    $display("FAIL test_reset inst=%0d cyc=%0d tick/busy/done=%b%b%b expected %b%b%b",
                             i, cyc, tick_v[i], busy_v[i], done_v[i], et, eb, ed);
                end
            end
            baud_set = 4'($urandom); div_custom = DW'($urandom);
            drive(k % 2 == 0, 1'b0, k == 5);
        end
    endtask

    task automatic test_table_rates();
        bit et, eb, ed;
        int s = 0;
        int tq[$], rq[$];
        baud_set = 4'd4;
        for (int k = 0; k < 1005; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                model(i, cyc, et, eb, ed);
                vectors++;
                if ({tick_v[i], busy_v[i], done_v[i]} !== {et, eb, ed}) begin
                    miscompares++;
                    $display("FAIL test_table_rates inst=%0d cyc=%0d tick/busy/done=%b%b%b expected %b%b%b",
                             i, cyc, tick_v[i], busy_v[i], done_v[i], et, eb, ed);
                end
            end
            if (k == 0) s = cyc;
            if (tick_v[0] === 1'b1) tq.push_back(cyc - s);
            if (tick_v[1] === 1'b1) rq.push_back(cyc - s);
            if (k == 300) begin baud_set = 4'd0; div_custom = DW'($urandom); end
            drive(k == 0 || k == 500, k == 1000, 1'b1);
        end
        vectors++;
        if (tq.size() < 3 || tq[0] != 1 || tq[1] != 435 || tq[2] != 869) begin
            miscompares++;
            $display("FAIL tx_115200_offsets got %p expected 1 435 869", tq);
        end
        vectors++;
        if (rq.size() < 2 || rq[0] != 218 || rq[1] != 652) begin
            miscompares++;
            $display("FAIL rx_115200_offsets got %p expected 218 652", rq);
        end
    endtask

    task automatic test_restart();
        bit et, eb, ed;
        int tq[$];
        baud_set = 4'd0;
        for (int k = 0; k < 10430; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                model(i, cyc, et, eb, ed);
                vectors++;
                if ({tick_v[i], busy_v[i], done_v[i]} !== {et, eb, ed}) begin
                    miscompares++;
                    $display("FAIL test_restart inst=%0d cyc=%0d tick/busy/done=%b%b%b expected %b%b%b",
                             i, cyc, tick_v[i], busy_v[i], done_v[i], et, eb, ed);
                end
            end
            if (tick_v[0] === 1'b1) tq.push_back(cyc);
            if (k == 2000) baud_set = 4'd7;
            drive(k == 0, k == 10425, 1'b1);
        end
        vectors++;
        if (tq.size() < 2 || tq[1] - tq[0] != 5208) begin
            miscompares++;
            $display("FAIL period_9600 got ticks %p expected spacing 5208", tq);
        end
    endtask

    task automatic test_custom();
        bit et, eb, ed;
        int tq[$];
        for (int p = 0; p < 2; p++) begin
            tq.delete();
            baud_set = 4'd8; div_custom = (p == 0) ? DW'(0) : DW'(9);
            for (int k = 0; k < 130; k++) begin
                @(negedge clk);
                for (int i = 0; i < 2; i++) begin
                    model(i, cyc, et, eb, ed);
                    vectors++;
                    if ({tick_v[i], busy_v[i], done_v[i]} !== {et, eb, ed}) begin
                        miscompares++;
                        $display("FAIL test_custom inst=%0d cyc=%0d tick/busy/done=%b%b%b expected %b%b%b",
                                 i, cyc, tick_v[i], busy_v[i], done_v[i], et, eb, ed);
                    end
                end
                if (tick_v[0] === 1'b1) tq.push_back(cyc);
                if (k == 5) div_custom = DW'($urandom);
                drive(k == 0, k == 125, 1'b1);
            end
            vectors++;
            if (tq.size() < 2 || tq[1] - tq[0] != ((p == 0) ? 2 : 10)) begin
                miscompares++;
                $display("FAIL custom_period_%0d got ticks %p expected spacing %0d", p, tq, (p == 0) ? 2 : 10);
            end
        end
    endtask

    task automatic test_autostop();
        bit et, eb, ed;
        int s = 0, nticks = 0, ndone = 0, done_off = -1;
        baud_set = 4'd8; div_custom = DW'(3);
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                model(i, cyc, et, eb, ed);
                vectors++;
                if ({tick_v[i], busy_v[i], done_v[i]} !== {et, eb, ed}) begin
                    miscompares++;
                    $display("FAIL test_autostop inst=%0d cyc=%0d tick/busy/done=%b%b%b expected %b%b%b",
                             i, cyc, tick_v[i], busy_v[i], done_v[i], et, eb, ed);
                end
            end
            if (k == 0) s = cyc;
            if (k < 60 && tick_v[0] === 1'b1) nticks++;
            if (k < 60 && done_v[0] === 1'b1) begin ndone++; done_off = cyc - s; end
            drive(k == 0, k == 65, 1'b1);
        end
        vectors++;
        if (nticks != (AUTO ? 10 : 15) || ndone != (AUTO ? 1 : 0) || done_off != (AUTO ? 37 : -1)) begin
            miscompares++;
            $display("FAIL autostop_frame got ticks=%0d dones=%0d done_at=%0d expected %0d %0d %0d",
                     nticks, ndone, done_off, AUTO ? 10 : 15, AUTO ? 1 : 0, AUTO ? 37 : -1);
        end
    endtask

    task automatic test_abort();
        bit et, eb, ed;
        baud_set = 4'd8; div_custom = DW'(3);
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                model(i, cyc, et, eb, ed);
                vectors++;
                if ({tick_v[i], busy_v[i], done_v[i]} !== {et, eb, ed}) begin
                    miscompares++;
                    $display("FAIL test_abort inst=%0d cyc=%0d tick/busy/done=%b%b%b expected %b%b%b",
                             i, cyc, tick_v[i], busy_v[i], done_v[i], et, eb, ed);
                end
            end
            drive(k == 0 || k == 4 || k == 16 || k == 25, k == 0 || k == 13 || k == 40, k != 23);
        end
    endtask

    task automatic test_random();
        bit et, eb, ed;
        int len, fin;
        for (int e = 0; e < 25; e++) begin
            len = $urandom_range(3, 150);
            fin = $urandom_range(0, 3);
            baud_set = 4'($urandom_range(5, 15));
            div_custom = DW'($urandom_range(0, 30));
            for (int k = 0; k <= len + 4; k++) begin
                @(negedge clk);
                for (int i = 0; i < 2; i++) begin
                    model(i, cyc, et, eb, ed);
                    vectors++;
                    if ({tick_v[i], busy_v[i], done_v[i]} !== {et, eb, ed}) begin
                        miscompares++;
                        $display("FAIL test_random ep=%0d inst=%0d cyc=%0d tick/busy/done=%b%b%b expected %b%b%b",
                                 e, i, cyc, tick_v[i], busy_v[i], done_v[i], et, eb, ed);
                    end
                end
                if (k > 0 && $urandom_range(0, 9) == 0) begin
                    baud_set = 4'($urandom); div_custom = DW'($urandom);
                end
                drive(k == 0 || (k < len && $urandom_range(0, 15) == 0),
                      (k == len && fin != 0) || (k == 0 && e % 7 == 3),
                      !(k == len && fin == 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_table_rates();
        test_restart();
        test_custom();
        test_autostop();
        test_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_baud_gen.md
UART_BAUD_GEN -- requirements
Module: uart_baud_gen

Interface
REQ-001 The block SHALL have parameter SYS_CLK, default 50_000_000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter OVERSAMPLE, default 1, ticks per bit period (legal values 1, 8, 16).
REQ-003 The block SHALL have parameter MODE, default 0, where 0 is TX (first tick immediately) and 1 is RX (first tick at half period).
REQ-004 The block SHALL have parameter DIV_W, default 16, divisor width; SYS_CLK/(9600*OVERSAMPLE) SHALL fit in DIV_W bits.
REQ-005 The block SHALL have parameter FRAME_BITS, default 10, bits per frame, used by autostop.
REQ-006 The block SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-007 The block SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-008 The block SHALL have port baud_set  input  4  rate select: 0..7 = 9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600; 8..15 = custom.
REQ-009 The block SHALL have port div_custom  input  DIV_W  custom divisor D, giving a period of D+1 cycles.
REQ-010 The block SHALL have port start  input  1  single-cycle request to begin ticking.
REQ-011 The block SHALL have port stop  input  1  single-cycle request to halt.
REQ-012 The block SHALL have port busy  output  1  high while the generator runs.
REQ-013 The block SHALL have port tick  output  1  registered single-cycle pulse marking each period.
REQ-014 The block SHALL have port done  output  1  single-cycle pulse on the final tick of an autostopped frame.

Function
REQ-015 The table divisor SHALL be D = SYS_CLK/(rate*OVERSAMPLE) - 1 (integer division), computed at elaboration.
REQ-016 The custom divisor SHALL be D = div_custom; a value below 1 SHALL be clamped to 1 (minimum period 2 cycles).
REQ-017 D SHALL be latched only when start is accepted; changes to baud_set or div_custom during RUN SHALL be ignored.
REQ-018 The FSM SHALL have exactly two states: IDLE (busy=0) and RUN (busy=1).
REQ-019 IDLE to RUN: start=1 and stop=0 in cycle n SHALL set busy=1 from cycle n+1.
REQ-020 In TX mode, the first tick SHALL occur at cycle n+1, with later ticks every D+1 cycles.
REQ-021 In RX mode, the first tick SHALL occur at cycle n+1+((D+1)>>1), with later ticks every D+1 cycles.
REQ-022 tick SHALL never be asserted in IDLE, and consecutive ticks SHALL never be closer than 2 cycles apart.
REQ-023 RUN to IDLE on stop=1 in cycle m: busy=0 from m+1, no tick from m+1 onward, and the period counter cleared.
REQ-024 If a tick is already high in cycle m when stop arrives, that tick SHALL complete normally.
REQ-025 When start and stop are both high in IDLE, stop SHALL win and the state SHALL remain IDLE.
REQ-026 start in RUN SHALL be ignored; it SHALL neither restart nor change phase.
REQ-027 The period counter SHALL be DIV_W bits wide and SHALL wrap from D to 0 without overflow.

Reset
REQ-028 While rst=0 at a clock edge: state=IDLE, counters=0, latched D = the 9600 divisor, tick=0, busy=0, done=0.
REQ-029 Reset asserted mid-RUN SHALL take priority over all inputs, and no tick SHALL appear in the following cycle.

Configuration
REQ-030 The block SHALL implement macro UART_BAUD_GEN_AUTOSTOP_EN.
REQ-031 With UART_BAUD_GEN_AUTOSTOP_EN defined, a tick counter SHALL count ticks in RUN.
REQ-032 With the macro defined, on tick number FRAME_BITS*OVERSAMPLE, done SHALL be 1 in the same cycle as that tick, and the state SHALL return to IDLE next cycle.
REQ-033 With the macro defined, stop SHALL still abort early, and done SHALL not pulse on an abort.
REQ-034 With UART_BAUD_GEN_AUTOSTOP_EN undefined, there SHALL be no tick counter, done SHALL be tied to 0, and the block SHALL run until stop or reset.

Verification
REQ-035 The bench SHALL cover: SYS_CLK=50M, OVERSAMPLE=1, MODE=0, baud_set=4, start pulse at cycle 0 -> ticks at cycles 1, 435, 869 (period 434).
REQ-036 The bench SHALL cover: MODE=1, baud_set=4 -> first tick at cycle 1+217=218, then every 434 cycles.
REQ-037 The bench SHALL cover: baud_set=8, div_custom=0 -> clamped to D=1, ticks every 2 cycles; div_custom=9 -> ticks every 10 cycles.
REQ-038 The bench SHALL cover: change baud_set 4->0 mid-RUN -> period stays 434; after stop and restart -> period 5208.
REQ-039 The bench SHALL cover: AUTOSTOP_EN, FRAME_BITS=10, OVERSAMPLE=1, custom D=3 -> 10 ticks 4 cycles apart, done on the 10th tick, busy low the next cycle.
REQ-040 The bench SHALL cover: rst=0 mid-RUN, and start+stop together in IDLE -> busy, tick and done all 0 next cycle, with no tick afterwards.
